cpu_axi_master_bridge: RTL

- Converts the custom CPU's simple single-word memory request/response port into a single-beat AXI4 master.
- Two instances are used: one for instruction fetch and one for data access.
- Each instance drives one slave port of the 2x1 AXI interconnect, which merges them onto the shared memory.
- At most one transaction is outstanding per instance. The block serialises requests and holds the CPU off until the AXI transaction completes.

---
 rtl/cpu_axi_pkg.sv | 27 ++
 rtl/cpu_axi_master_bridge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared encodings and helpers for the CPU-to-AXI master bridge
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_WAIT_B   = 3'd2,
    ST_READ_AR  = 3'd3,
    ST_READ_R   = 3'd4,
    ST_READ_OUT = 3'd5
  } bridge_state_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  // Ceiling log2, used for the beat size and the address alignment mask.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cpu_axi_master_bridge.sv
// rtl/cpu_axi_master_bridge.sv - single-beat AXI4 master behind the CPU memory port
module cpu_axi_master_bridge
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int ID_VALUE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  // CPU side
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_wstrb,
  input  logic                  mem_ren,
  output logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rdata_valid,
  input  logic                  mem_rdata_ready,
  output logic                  resp_err,
  // AXI write address
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [3:0]            m_axi_awregion,
  output logic                  m_axi_awuser,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wuser,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_buser,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI read address
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic                  m_axi_aruser,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_ruser,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int              ADDR_LSB = clog2(STRB_WIDTH);
  localparam logic [2:0]      AXI_SIZE = 3'(ADDR_LSB);
  localparam logic [ID_WIDTH-1:0] AXI_ID = ID_WIDTH'(ID_VALUE);

  bridge_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  resp_err_q, resp_err_d;

  logic accept;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // IDs, user bits and the low address bits are not needed with one outstanding beat.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_buser, m_axi_rid, m_axi_ruser,
                           mem_addr[ADDR_LSB-1:0]};

  assign mem_req_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = mem_req_ready && (mem_wen || mem_ren);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid  && m_axi_wready;
  assign b_hs  = m_axi_bvalid  && m_axi_bready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rvalid  && m_axi_rready;

  // Fixed single-beat attributes; both address channels share the same register.
  assign m_axi_awid     = AXI_ID;
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = 8'd0;
  assign m_axi_awsize   = AXI_SIZE;
  assign m_axi_awburst  = AXI_BURST_INCR;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = AXI_CACHE_DEFAULT;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awuser   = 1'b0;

  assign m_axi_wdata    = wdata_q;
  assign m_axi_wstrb    = wstrb_q;
  assign m_axi_wlast    = 1'b1;
  assign m_axi_wuser    = 1'b0;

  assign m_axi_arid     = AXI_ID;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = 8'd0;
  assign m_axi_arsize   = AXI_SIZE;
  assign m_axi_arburst  = AXI_BURST_INCR;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = AXI_CACHE_DEFAULT;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_aruser   = 1'b0;

  assign mem_rdata = rdata_q;
  assign resp_err  = resp_err_q;

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Next state, request capture, per-channel done tracking and sticky error.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    resp_err_d = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d    = {mem_addr[ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          // A simultaneous read request is dropped in favour of the write.
          state_d   = mem_wen ? ST_WRITE : ST_READ_AR;
        end
      end
      ST_WRITE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (b_hs) begin
          state_d = ST_IDLE;
          if (m_axi_bresp != AXI_RESP_OKAY) resp_err_d = 1'b1;
        end
      end
      ST_READ_AR: begin
        if (ar_hs) state_d = ST_READ_R;
      end
      ST_READ_R: begin
        if (r_hs) begin
          rdata_d = m_axi_rdata;
          state_d = ST_READ_OUT;
          if ((m_axi_rresp != AXI_RESP_OKAY) || !m_axi_rlast) resp_err_d = 1'b1;
        end
      end
      ST_READ_OUT: begin
        if (mem_rdata_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel valids/readies decoded from the registered state only.
  always_comb begin
    m_axi_awvalid   = 1'b0;
    m_axi_wvalid    = 1'b0;
    m_axi_bready    = 1'b0;
    m_axi_arvalid   = 1'b0;
    m_axi_rready    = 1'b0;
    mem_rdata_valid = 1'b0;
    case (state_q)
      ST_WRITE: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
      end
      ST_WAIT_B:   m_axi_bready    = 1'b1;
      ST_READ_AR:  m_axi_arvalid   = 1'b1;
      ST_READ_R:   m_axi_rready    = 1'b1;
      ST_READ_OUT: mem_rdata_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
